// File: rtl/magic_matcher.sv
// magic_matcher: template-matching classifier. Streams class masks from an external
// synchronous ROM, accumulates per-class hit (son) and union (mom) scores, then ranks
// the classes serially by son/mom ratio using cross-multiplication.
module magic_matcher #(
    parameter int unsigned IMG_W       = 30,
    parameter int unsigned IMG_H       = 30,
    parameter int unsigned N_CLASS     = 10,
    parameter int unsigned PIX_PER_CYC = 1,
    parameter int unsigned HIT_W       = 2,
    localparam int unsigned NPIX       = IMG_W * IMG_H,
    localparam int unsigned G          = NPIX / PIX_PER_CYC,
    localparam int unsigned ACC_W      = $clog2(HIT_W * NPIX + 1),
    localparam int unsigned CLS_W      = $clog2(N_CLASS),
    localparam int unsigned ADDR_W     = (G > 1) ? $clog2(G) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [NPIX-1:0]                i_image,
    output logic [ADDR_W-1:0]              o_mask_addr,
    input  logic [N_CLASS*PIX_PER_CYC-1:0] i_mask_data,
    output logic                           o_busy,
    output logic                           o_valid,
    output logic [CLS_W-1:0]               o_digit,
    output logic [ACC_W-1:0]               o_son,
    output logic [ACC_W-1:0]               o_mom
);

    localparam int unsigned P      = PIX_PER_CYC;
    localparam int unsigned PROD_W = 2 * ACC_W;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StDrain,
        StRank,
        StDone
    } state_e;

    state_e r_state, w_state_next;

    logic [NPIX-1:0]    r_image;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_acc_grp;
    logic               r_acc_en;
    logic [CLS_W-1:0]   r_rank_idx;
    logic [ACC_W-1:0]   r_best_son;
    logic [ACC_W-1:0]   r_best_mom;
    logic [CLS_W-1:0]   r_best_idx;
    logic [CLS_W-1:0]   r_digit;
    logic [ACC_W-1:0]   r_out_son;
    logic [ACC_W-1:0]   r_out_mom;

    logic               w_start;
    logic               w_abort;
    logic               w_last_addr;
    logic               w_last_cls;
    logic [P-1:0]       w_pix;
    logic [ACC_W-1:0]   w_son [N_CLASS];
    logic [ACC_W-1:0]   w_mom [N_CLASS];
    logic [ACC_W-1:0]   w_cand_son;
    logic [ACC_W-1:0]   w_cand_mom;
    logic [PROD_W-1:0]  w_lhs;
    logic [PROD_W-1:0]  w_rhs;
    logic               w_take;

    assign w_start     = (r_state == StIdle) && i_start;
    assign w_abort     = i_abort && (r_state inside {StScan, StDrain, StRank});
    assign w_last_addr = (r_addr == ADDR_W'(G - 1));
    assign w_last_cls  = (r_rank_idx == CLS_W'(N_CLASS - 1));

    // Next-state logic; abort overrides any normal advance
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StScan;
            StScan:  if (w_last_addr) w_state_next = StDrain;
            StDrain: w_state_next = StRank;
            StRank:  if (w_last_cls) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        if (w_abort) begin
            w_state_next = StIdle;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Image capture on accepted start
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_image <= '0;
        end else if (w_start) begin
            r_image <= i_image;
        end
    end

    // Group address counter; holds at G-1 outside SCAN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= '0;
        end else if (w_start) begin
            r_addr <= '0;
        end else if (r_state == StScan && !w_last_addr && !w_abort) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // ROM data lags the address by one cycle, so the accumulate strobe does too
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_en  <= 1'b0;
            r_acc_grp <= '0;
        end else begin
            r_acc_en  <= (r_state == StScan) && !w_abort;
            r_acc_grp <= r_addr;
        end
    end

    // Image pixels belonging to the group whose mask data is arriving now
    assign w_pix = P'(r_image >> (32'(r_acc_grp) * P));

    for (genvar c = 0; c < N_CLASS; c++) begin : g_cls
        logic [P-1:0]     w_m;
        logic [P-1:0]     w_hit;
        logic [P-1:0]     w_diff;
        logic [ACC_W-1:0] w_son_inc;
        logic [ACC_W-1:0] w_mom_inc;
        logic [ACC_W-1:0] r_son;
        logic [ACC_W-1:0] r_mom;

        assign w_m       = i_mask_data[c*P +: P];
        assign w_hit     = w_pix & w_m;
        assign w_diff    = w_pix ^ w_m;
        assign w_son_inc = ACC_W'(HIT_W) * ACC_W'($countones(w_hit));
        assign w_mom_inc = w_son_inc + ACC_W'($countones(w_diff));

        // Per-class score accumulators, cleared on accepted start
        always_ff @(posedge i_clk) begin
            if (i_rst || w_start) begin
                r_son <= '0;
                r_mom <= '0;
            end else if (r_acc_en) begin
                r_son <= r_son + w_son_inc;
                r_mom <= r_mom + w_mom_inc;
            end
        end

        assign w_son[c] = r_son;
        assign w_mom[c] = r_mom;
    end

    // Ratio compare without division: son_c/mom_c > son_b/mom_b via cross products.
    // Strict '>' keeps the lower index on ties.
    assign w_cand_son = w_son[r_rank_idx];
    assign w_cand_mom = w_mom[r_rank_idx];
    assign w_lhs      = PROD_W'(w_cand_son) * PROD_W'(r_best_mom);
    assign w_rhs      = PROD_W'(r_best_son) * PROD_W'(w_cand_mom);
    assign w_take     = (r_rank_idx == '0) || (w_lhs > w_rhs);

    // Serial ranking, one class per cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rank_idx <= '0;
            r_best_son <= '0;
            r_best_mom <= '0;
            r_best_idx <= '0;
        end else if (r_state == StRank && !w_abort) begin
            if (w_take) begin
                r_best_son <= w_cand_son;
                r_best_mom <= w_cand_mom;
                r_best_idx <= r_rank_idx;
            end
            r_rank_idx <= w_last_cls ? '0 : r_rank_idx + CLS_W'(1);
        end else begin
            r_rank_idx <= '0;
        end
    end

    // Result registers load on the final rank step so they are valid during DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digit   <= '0;
            r_out_son <= '0;
            r_out_mom <= '0;
        end else if (r_state == StRank && w_last_cls && !w_abort) begin
            r_digit   <= w_take ? r_rank_idx : r_best_idx;
            r_out_son <= w_take ? w_cand_son : r_best_son;
            r_out_mom <= w_take ? w_cand_mom : r_best_mom;
        end
    end

    assign o_mask_addr = r_addr;
    assign o_busy      = r_state inside {StScan, StDrain, StRank};
    assign o_valid     = (r_state == StDone);
    assign o_digit     = r_digit;
    assign o_son       = r_out_son;
    assign o_mom       = r_out_mom;

endmodule

// File: tb/tb_magic_matcher.sv
// Bench for magic_matcher: P=1 and P=4 instances, each with a registered mask ROM model.
// Stimulus pushes expected results into per-instance queues; monitors check on o_valid.
module tb_magic_matcher;

    localparam int unsigned N_CLASS = 10;
    localparam int unsigned NPIX    = 900;
    localparam int unsigned ACC_W   = 11;
    localparam int unsigned CLS_W   = 4;
    localparam int unsigned AW1     = 10;
    localparam int unsigned AW4     = 8;

    typedef struct {
        int digit;
        int son;
        int mom;
        int at;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int t0_1 = 0;
    int t0_4 = 0;

    logic clk = 1'b0;
    logic rst;
    logic start1, abort1, start4, abort4;
    logic [NPIX-1:0] image1, image4;
    logic [NPIX-1:0] masks [N_CLASS];

    logic [AW1-1:0]       addr1;
    logic [N_CLASS-1:0]   mdata1;
    logic                 busy1, valid1;
    logic [CLS_W-1:0]     digit1;
    logic [ACC_W-1:0]     son1, mom1;

    logic [AW4-1:0]       addr4;
    logic [N_CLASS*4-1:0] mdata4;
    logic                 busy4, valid4;
    logic [CLS_W-1:0]     digit4;
    logic [ACC_W-1:0]     son4, mom4;

    logic [0:0] rom1 [N_CLASS];
    logic [3:0] rom4 [N_CLASS];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    magic_matcher #(.PIX_PER_CYC(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(abort1), .i_image(image1),
        .o_mask_addr(addr1), .i_mask_data(mdata1), .o_busy(busy1), .o_valid(valid1),
        .o_digit(digit1), .o_son(son1), .o_mom(mom1)
    );

    magic_matcher #(.PIX_PER_CYC(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_abort(abort4), .i_image(image4),
        .o_mask_addr(addr4), .i_mask_data(mdata4), .o_busy(busy4), .o_valid(valid4),
        .o_digit(digit4), .o_son(son4), .o_mom(mom4)
    );

    // Registered mask ROMs: data appears one cycle after the address
    for (genvar c = 0; c < N_CLASS; c++) begin : g_rom
        always @(posedge clk) begin
            rom1[c] <= 1'(masks[c] >> (32'(addr1) * 1));
            rom4[c] <= 4'(masks[c] >> (32'(addr4) * 4));
        end
        assign mdata1[c]       = rom1[c];
        assign mdata4[c*4 +: 4] = rom4[c];
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [NPIX-1:0] span(input int lo, input int n);
        return ((NPIX'(1) << n) - NPIX'(1)) << lo;
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (valid1) begin
            if (q1.size() == 0) begin
                check("unexpected_valid1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("digit1", int'(digit1), e.digit);
                check("son1", int'(son1), e.son);
                check("mom1", int'(mom1), e.mom);
                check("valid_edge1", edge_cnt, e.at);
            end
        end
    end

    always @(negedge clk) begin
        if (valid4) begin
            if (q4.size() == 0) begin
                check("unexpected_valid4", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("digit4", int'(digit4), e.digit);
                check("son4", int'(son4), e.son);
                check("mom4", int'(mom4), e.mom);
                check("valid_edge4", edge_cnt, e.at);
            end
        end
    end

    task automatic set_masks(input int kind);
        for (int c = 0; c < N_CLASS; c++) begin
            case (kind)
                0:       masks[c] = span(c * 100, c + 1);
                1:       masks[c] = (c == 3) ? span(0, 40) : span(100 + c * 50, 10);
                default: masks[c] = (c == 2) ? span(0, 40) :
                                    (c == 5) ? span(0, 10) : span(100 + c * 50, 10);
            endcase
        end
    endtask

    // Issue a start to the P=1 instance at a negedge; optionally queue its expected result
    task automatic go1(input logic [NPIX-1:0] img, input int d, input int s, input int m,
                       input bit expect_res);
        image1 = img;
        start1 = 1'b1;
        t0_1 = edge_cnt;
        if (expect_res) q1.push_back('{d, s, m, t0_1 + 912});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_cyc1(input int k);
        while (edge_cnt - t0_1 < k) @(negedge clk);
    endtask

    task automatic drain1(input int budget);
        int n = 0;
        while (q1.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0) begin
            check("timeout1_outstanding", q1.size(), 0);
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic drain4(input int budget);
        int n = 0;
        while (q4.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) begin
            check("timeout4_outstanding", q4.size(), 0);
            q4.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sweep_err;
        rst = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; image1 = '0;
        start4 = 1'b0; abort4 = 1'b0; image4 = '0;
        set_masks(0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", int'(busy1), 0);
        check("rst_valid", int'(valid1), 0);
        check("rst_digit", int'(digit1), 0);
        check("rst_son", int'(son1), 0);
        check("rst_mom", int'(mom1), 0);
        check("rst_addr", int'(addr1), 0);
        check("rst_busy4", int'(busy4), 0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero image: every ratio is 0, class 0 wins the tie with mom=1
        set_masks(0);
        go1('0, 0, 0, 1, 1'b1);
        check("busy_cycle1", int'(busy1), 1);
        drain1(1000);

        // Image equals class 3 mask; start held during DONE must be ignored
        set_masks(1);
        go1(span(0, 40), 3, 80, 80, 1'b1);
        wait_cyc1(912);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("start_in_done_busy", int'(busy1), 0);
        drain1(10);

        // Classes 2 and 5 tie at 2/3; lower index wins
        set_masks(2);
        go1(span(0, 20), 2, 40, 60, 1'b1);
        drain1(1000);

        // P=4 instance, class 3 image, address sweep 0..224
        set_masks(1);
        image4 = span(0, 40);
        start4 = 1'b1;
        t0_4 = edge_cnt;
        q4.push_back('{3, 80, 80, t0_4 + 237});
        @(negedge clk);
        start4 = 1'b0;
        sweep_err = 0;
        for (int k = 1; k <= 225; k++) begin
            if (int'(addr4) != k - 1) sweep_err++;
            @(negedge clk);
        end
        check("addr4_sweep_errors", sweep_err, 0);
        check("addr4_hold_drain", int'(addr4), 224);
        drain4(300);

        // Abort at cycle 500: idle next cycle, previous result held, no strobe
        go1(span(0, 40), 0, 0, 0, 1'b0);
        wait_cyc1(500);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("abort_busy", int'(busy1), 0);
        check("abort_digit_held", int'(digit1), 2);
        check("abort_son_held", int'(son1), 40);
        check("abort_mom_held", int'(mom1), 60);
        repeat (450) @(negedge clk);

        // Fresh start completes; a start pulse mid-job is ignored
        go1(span(0, 40), 3, 80, 80, 1'b1);
        wait_cyc1(300);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        drain1(1000);

        // Reset at cycle 910 discards the job and clears outputs
        set_masks(2);
        go1(span(0, 20), 0, 0, 0, 1'b0);
        wait_cyc1(910);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy1), 0);
        check("midrst_valid", int'(valid1), 0);
        check("midrst_digit", int'(digit1), 0);
        check("midrst_son", int'(son1), 0);
        check("midrst_mom", int'(mom1), 0);
        check("midrst_addr", int'(addr1), 0);
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
